// File: rtl/rr_sel_8_1.sv
// rr_sel_8_1: round-robin select generator for an 8:1 channel mux.
// Arbitrates eight requesters and drives a registered select/grant with a
// valid/ready handshake toward the consumer. A grant ends on a transfer, on
// withdrawal of the request, or after TIMEOUT cycles without a transfer.
module rr_sel_8_1 #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid,
  output logic [7:0] ack,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A TIMEOUT of 0 disables the hold timer; otherwise the grant drops when
  // the hold counter reaches TIMEOUT-1.
  localparam logic       to_en   = (TIMEOUT != 0);
  localparam logic [7:0] to_last = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [2:0] sel_reg, sel_next;
  logic [7:0] gnt_reg, gnt_next;
  logic       valid_reg, valid_next;
  logic       timeout_reg, timeout_next;
  logic [7:0] hcnt_reg, hcnt_next;

  // First set bit of mask at or after start, searching cyclically 7 -> 0.
  function automatic logic [2:0] pick(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // State and output registers; reset aborts any grant without ack/timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= 3'd0;
      sel_reg     <= 3'd0;
      gnt_reg     <= 8'd0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      hcnt_reg    <= 8'd0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      sel_reg     <= sel_next;
      gnt_reg     <= gnt_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
      hcnt_reg    <= hcnt_next;
    end
  end

  logic       xfer;
  logic       withdraw;
  logic       expire;
  logic [7:0] rearb_mask;
  logic [2:0] rearb_start;

  // Next-state: arbitration from IDLE, and grant termination with
  // priority transfer > withdrawal > timeout followed by same-edge
  // re-arbitration that excludes the source just served.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    sel_next     = sel_reg;
    gnt_next     = gnt_reg;
    valid_next   = valid_reg;
    timeout_next = 1'b0;
    hcnt_next    = hcnt_reg;
    xfer         = out_ready;
    withdraw     = !req[sel_reg];
    expire       = to_en && (hcnt_reg == to_last);
    rearb_mask   = req & ~gnt_reg;
    rearb_start  = sel_reg + 3'd1;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = GRANT;
          sel_next   = pick(req, ptr_reg);
          gnt_next   = 8'b1 << sel_next;
          valid_next = 1'b1;
          hcnt_next  = 8'd0;
        end
      end
      GRANT: begin
        if (xfer || withdraw || expire) begin
          // Timeout pulse only when neither higher-priority event applies.
          timeout_next = !xfer && !withdraw;
          ptr_next     = rearb_start;
          if (|rearb_mask) begin
            sel_next   = pick(rearb_mask, rearb_start);
            gnt_next   = 8'b1 << sel_next;
            valid_next = 1'b1;
            hcnt_next  = 8'd0;
          end else begin
            state_next = IDLE;
            gnt_next   = 8'd0;
            valid_next = 1'b0;
          end
        end else if (hcnt_reg != 8'hFF) begin
          hcnt_next = hcnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Same-cycle acknowledge toward the granted requester.
  for (genvar gi = 0; gi < 8; gi++) begin : g_ack
    assign ack[gi] = gnt_reg[gi] & valid_reg & out_ready;
  end

  assign sel     = sel_reg;
  assign gnt     = gnt_reg;
  assign valid   = valid_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_sel_8_1.sv
// Directed testbench for rr_sel_8_1: one DUT with TIMEOUT=15, one with TIMEOUT=4.
module tb_rr_sel_8_1;

  logic       clk;
  logic       rst_n;
  logic [7:0] req, req4;
  logic       out_ready, rdy4;
  logic [2:0] sel, sel4;
  logic [7:0] gnt, gnt4;
  logic       valid, valid4;
  logic [7:0] ack, ack4;
  logic       timeout, timeout4;

  int vectors = 0;
  int miscompares = 0;

  rr_sel_8_1 #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel), .gnt(gnt), .valid(valid), .ack(ack), .timeout(timeout)
  );

  rr_sel_8_1 #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .out_ready(rdy4),
    .sel(sel4), .gnt(gnt4), .valid(valid4), .ack(ack4), .timeout(timeout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'h00; out_ready = 1'b0; req4 = 8'h00; rdy4 = 1'b0;
    step(); step();
    vectors++;
    if (sel !== 3'd0 || gnt !== 8'h00 || valid !== 1'b0 || ack !== 8'h00 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got sel=%0d gnt=%h valid=%b ack=%h timeout=%b want 0/00/0/00/0",
               sel, gnt, valid, ack, timeout);
    end
    rst_n = 1'b1;
    $display("reset: sel=%0d gnt=%h valid=%b", sel, gnt, valid);
  endtask

  task automatic test_single();
    req = 8'h04; out_ready = 1'b0;
    step();
    vectors++;
    if (sel !== 3'd2 || gnt !== 8'h04 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant got sel=%0d gnt=%h valid=%b want 2/04/1", sel, gnt, valid);
    end
    out_ready = 1'b1; #1;
    vectors++;
    if (ack !== 8'h04) begin
      miscompares++;
      $display("FAIL single_ack got %h want 04", ack);
    end
    req = 8'h00;
    step();
    vectors++;
    if (valid !== 1'b0 || gnt !== 8'h00 || sel !== 3'd2 || ack !== 8'h00) begin
      miscompares++;
      $display("FAIL single_idle got valid=%b gnt=%h sel=%0d ack=%h want 0/00/2/00", valid, gnt, sel, ack);
    end
    out_ready = 1'b0;
    $display("single: sel=%0d valid=%b", sel, valid);
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_sel;
    logic [7:0] exp_ack;
    pulse_reset();
    req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_sel = 3'(i % 8);
      exp_ack = 8'b1 << exp_sel;
      vectors++;
      if (sel !== exp_sel || ack !== exp_ack) begin
        miscompares++;
        $display("FAIL rr_step%0d got sel=%0d ack=%h want sel=%0d ack=%h", i, sel, ack, exp_sel, exp_ack);
      end
      $display("rr[%0d]: sel=%0d ack=%h", i, sel, ack);
    end
    req = 8'h00; out_ready = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b0 || ack !== 8'h00) begin
      miscompares++;
      $display("FAIL rr_release got valid=%b ack=%h want 0/00", valid, ack);
    end
  endtask

  task automatic test_backpressure();
    pulse_reset();
    req = 8'h81; out_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (sel !== 3'd0 || valid !== 1'b1 || ack !== 8'h00 || gnt !== 8'h01) begin
        miscompares++;
        $display("FAIL bp_hold%0d got sel=%0d valid=%b ack=%h gnt=%h want 0/1/00/01", k, sel, valid, ack, gnt);
      end
      $display("bp[%0d]: sel=%0d valid=%b", k, sel, valid);
      if (k < 4) step();
    end
    out_ready = 1'b1; #1;
    vectors++;
    if (ack !== 8'h01) begin
      miscompares++;
      $display("FAIL bp_ack got %h want 01", ack);
    end
    req = 8'h80;
    step();
    vectors++;
    if (sel !== 3'd7 || gnt !== 8'h80 || ack !== 8'h80) begin
      miscompares++;
      $display("FAIL bp_next got sel=%0d gnt=%h ack=%h want 7/80/80", sel, gnt, ack);
    end
    req = 8'h00;
    step();
    out_ready = 1'b0;
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_idle got valid=%b want 0", valid);
    end
  endtask

  task automatic test_timeout();
    req4 = 8'h30; rdy4 = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (sel4 !== 3'd4 || valid4 !== 1'b1 || timeout4 !== 1'b0) begin
        miscompares++;
        $display("FAIL to_hold4_%0d got sel=%0d valid=%b timeout=%b want 4/1/0", c, sel4, valid4, timeout4);
      end
      step();
    end
    vectors++;
    if (sel4 !== 3'd5 || timeout4 !== 1'b1) begin
      miscompares++;
      $display("FAIL to_drop4 got sel=%0d timeout=%b want 5/1", sel4, timeout4);
    end
    $display("timeout: sel=%0d pulse=%b", sel4, timeout4);
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (sel4 !== 3'd5 || (c > 0 && timeout4 !== 1'b0)) begin
        miscompares++;
        $display("FAIL to_hold5_%0d got sel=%0d timeout=%b want 5", c, sel4, timeout4);
      end
      step();
    end
    vectors++;
    if (sel4 !== 3'd4 || timeout4 !== 1'b1) begin
      miscompares++;
      $display("FAIL to_back4 got sel=%0d timeout=%b want 4/1", sel4, timeout4);
    end
    $display("timeout: sel=%0d pulse=%b", sel4, timeout4);
    req4 = 8'h00;
    step();
    vectors++;
    if (valid4 !== 1'b0) begin
      miscompares++;
      $display("FAIL to_release got valid=%b want 0", valid4);
    end
  endtask

  task automatic test_withdrawal();
    req = 8'h08; out_ready = 1'b0;
    step();
    vectors++;
    if (sel !== 3'd3 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_grant got sel=%0d valid=%b want 3/1", sel, valid);
    end
    req = 8'h00; #1;
    step();
    vectors++;
    if (valid !== 1'b0 || gnt !== 8'h00 || ack !== 8'h00 || timeout !== 1'b0 || sel !== 3'd3) begin
      miscompares++;
      $display("FAIL wd_drop got valid=%b gnt=%h ack=%h timeout=%b sel=%0d want 0/00/00/0/3",
               valid, gnt, ack, timeout, sel);
    end
    $display("withdraw: valid=%b sel=%0d", valid, sel);
  endtask

  task automatic test_simultaneous();
    req4 = 8'h01; rdy4 = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (sel4 !== 3'd0 || valid4 !== 1'b1) begin
        miscompares++;
        $display("FAIL sim_hold%0d got sel=%0d valid=%b want 0/1", c, sel4, valid4);
      end
      step();
    end
    rdy4 = 1'b1; #1;
    vectors++;
    if (ack4 !== 8'h01) begin
      miscompares++;
      $display("FAIL sim_ack got %h want 01", ack4);
    end
    req4 = 8'h00;
    step();
    vectors++;
    if (timeout4 !== 1'b0 || valid4 !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_no_timeout got timeout=%b valid=%b want 0/0", timeout4, valid4);
    end
    rdy4 = 1'b0;
    $display("simultaneous: timeout=%b valid=%b", timeout4, valid4);
  endtask

  task automatic test_async_reset();
    req = 8'hFF; out_ready = 1'b0;
    step();
    out_ready = 1'b1; #1;
    vectors++;
    if (sel !== 3'd4 || ack !== 8'h10) begin
      miscompares++;
      $display("FAIL ar_pre got sel=%0d ack=%h want 4/10", sel, ack);
    end
    rst_n = 1'b0; #1;
    vectors++;
    if (valid !== 1'b0 || gnt !== 8'h00 || ack !== 8'h00 || sel !== 3'd0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_during got valid=%b gnt=%h ack=%h sel=%0d timeout=%b want 0/00/00/0/0",
               valid, gnt, ack, sel, timeout);
    end
    out_ready = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    vectors++;
    if (sel !== 3'd0 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_ptr got sel=%0d valid=%b want 0/1", sel, valid);
    end
    $display("async reset: sel=%0d valid=%b", sel, valid);
    req = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_withdrawal();
    test_simultaneous();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
